// File: rtl/register_file.sv
// register_file: 16x16 register file, two combinational read ports, two write ports (port 2 wins on collision).
// Optional write-to-read forwarding under RF_BYPASS_EN.
module register_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg1,
  input  logic [ADDR_W-1:0] WriteReg2,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic [DATA_W-1:0] WriteData2,
  input  logic              RegWrite,
  input  logic              WriteOP2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] R15
);
  localparam int N = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TOP = '1;
  logic [DATA_W-1:0] r_regs [N];
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < N; i++) r_regs[i] <= '0;
    else begin
      if (RegWrite) r_regs[WriteReg1] <= WriteData1;
      if (WriteOP2) r_regs[WriteReg2] <= WriteData2;
    end
`ifdef RF_BYPASS_EN
  // Port 2 is checked first so it also wins when forwarding a collision.
  logic w_h2_1, w_h1_1, w_h2_2, w_h1_2, w_h2_t, w_h1_t;
  assign w_h2_1 = rst && WriteOP2 && WriteReg2 == ReadReg1;
  assign w_h1_1 = rst && RegWrite && WriteReg1 == ReadReg1;
  assign w_h2_2 = rst && WriteOP2 && WriteReg2 == ReadReg2;
  assign w_h1_2 = rst && RegWrite && WriteReg1 == ReadReg2;
  assign w_h2_t = rst && WriteOP2 && WriteReg2 == TOP;
  assign w_h1_t = rst && RegWrite && WriteReg1 == TOP;
  assign ReadData1 = w_h2_1 ? WriteData2 : w_h1_1 ? WriteData1 : r_regs[ReadReg1];
  assign ReadData2 = w_h2_2 ? WriteData2 : w_h1_2 ? WriteData1 : r_regs[ReadReg2];
  assign R15       = w_h2_t ? WriteData2 : w_h1_t ? WriteData1 : r_regs[TOP];
`else
  assign ReadData1 = r_regs[ReadReg1];
  assign ReadData2 = r_regs[ReadReg2];
  assign R15       = r_regs[TOP];
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vectors; expected outputs queued by stimulus, compared by a separate monitor.
module tb_register_file;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ReadReg1, ReadReg2, WriteReg1, WriteReg2;
  logic [15:0] WriteData1, WriteData2;
  logic        RegWrite, WriteOP2;
  logic [15:0] ReadData1, ReadData2, R15;
  typedef struct {
    string       name;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] e15;
  } exp_t;
  exp_t q[$];
  event ev_chk;
  int tests = 0;
  int failed = 0;
  always #5 clk = ~clk;
  register_file dut (
    .clk(clk), .rst(rst),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg1(WriteReg1), .WriteReg2(WriteReg2),
    .WriteData1(WriteData1), .WriteData2(WriteData2),
    .RegWrite(RegWrite), .WriteOP2(WriteOP2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .R15(R15)
  );
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    exp_t e;
    e.name = n;
    e.e1 = a;
    e.e2 = b;
    e.e15 = c;
    q.push_back(e);
    ->ev_chk;
    #1;
  endtask
  task automatic wr(input logic we1, input logic [3:0] a1, input logic [15:0] d1,
                    input logic we2, input logic [3:0] a2, input logic [15:0] d2);
    RegWrite = we1;
    WriteReg1 = a1;
    WriteData1 = d1;
    WriteOP2 = we2;
    WriteReg2 = a2;
    WriteData2 = d2;
  endtask
  task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
    ReadReg1 = a1;
    ReadReg2 = a2;
  endtask
  task automatic edge_chk(input string n, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    @(posedge clk);
    #1;
    chk(n, a, b, c);
  endtask
  initial begin : monitor
    exp_t t;
    forever begin
      @(ev_chk);
      while (q.size() > 0) begin
        t = q.pop_front();
        tests++;
        if (ReadData1 !== t.e1 || ReadData2 !== t.e2 || R15 !== t.e15) begin
          failed++;
          $display("FAIL %s: got rd1=%h rd2=%h r15=%h, expected rd1=%h rd2=%h r15=%h",
                   t.name, ReadData1, ReadData2, R15, t.e1, t.e2, t.e15);
        end
      end
    end
  end
  initial begin : stim
    rst = 1'b0;
    wr(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    rd(4'd3, 4'd9);
    #2 chk("reset_a", 16'h0, 16'h0, 16'h0);
    rd(4'd15, 4'd0);
    chk("reset_b", 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    wr(1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd10, 16'd2000);
    rd(4'd15, 4'd10);
    #1 chk("dual_pre", BYP ? 16'hFFFF : 16'h0, BYP ? 16'h07D0 : 16'h0, BYP ? 16'hFFFF : 16'h0);
    edge_chk("dual_post", 16'hFFFF, 16'h07D0, 16'hFFFF);
    @(negedge clk);
    wr(1'b0, 4'd3, 16'h1234, 1'b0, 4'd3, 16'h9999);
    rd(4'd3, 4'd15);
    edge_chk("gate_off", 16'h0, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    RegWrite = 1'b1;
    #1 chk("gate_pre", BYP ? 16'h1234 : 16'h0, 16'hFFFF, 16'hFFFF);
    edge_chk("gate_on", 16'h1234, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    wr(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'h5555);
    rd(4'd5, 4'd3);
    #1 chk("coll_pre", BYP ? 16'h5555 : 16'h0, 16'h1234, 16'hFFFF);
    edge_chk("collision", 16'h5555, 16'h1234, 16'hFFFF);
    @(negedge clk);
    wr(1'b0, 4'd5, 16'h0BAD, 1'b0, 4'd10, 16'h0BAD);
    rd(4'd10, 4'd5);
    repeat (3) @(posedge clk);
    #1 chk("hold", 16'h07D0, 16'h5555, 16'hFFFF);
    @(negedge clk);
    wr(1'b1, 4'd15, 16'h8001, 1'b1, 4'd0, 16'h0001);
    rd(4'd0, 4'd15);
    edge_chk("r0_r15", 16'h0001, 16'h8001, 16'h8001);
    @(negedge clk);
    wr(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    rd(4'd15, 4'd10);
    #2 rst = 1'b0;
    #1 chk("async_rst", 16'h0, 16'h0, 16'h0);
    wr(1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 16'h0);
    rd(4'd7, 4'd5);
    edge_chk("wr_in_rst", 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("resume_pre", BYP ? 16'h7777 : 16'h0, 16'h0, 16'h0);
    edge_chk("resume", 16'h7777, 16'h0, 16'h0);
    @(negedge clk);
    wr(1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0, 16'h0);
    #1 chk("bypass_pre", BYP ? 16'hBEEF : 16'h7777, 16'h0, 16'h0);
    edge_chk("bypass_post", 16'hBEEF, 16'h0, 16'h0);
    for (int i = 0; i < 20 && q.size() > 0; i++) #1;
    if (q.size() > 0) begin
      $display("FAIL scoreboard: got %0d unchecked entries, expected 0", q.size());
      failed += q.size();
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
